// File: rtl/hall_conditioner.sv
// Hall sensor front end: synchronizes and debounces the raw Hall code, rejects illegal codes,
// and derives direction, signed step position and commutation period for one BLDC motor.
module hall_conditioner #(
  parameter int FILTER_CYCLES = 8,
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2:0]              h_raw,
  input  logic                    clear_count,
  output logic [2:0]              h,
  output logic                    h_valid,
  output logic                    fault,
  output logic                    dir,
  output logic                    edge_pulse,
  output logic [COUNT_WIDTH-1:0]  position,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled
);

  localparam int STAB_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [STAB_W-1:0]       STAB_MAX  = STAB_W'(FILTER_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] TIMER_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] TIMER_PRE = TIMER_MAX - PERIOD_WIDTH'(1);

  logic [2:0]              sync_a;
  logic [2:0]              sync_s;
  logic [2:0]              cand;
  logic [STAB_W-1:0]       stab;
  logic [2:0]              acc_code;
  logic [PERIOD_WIDTH-1:0] timer;
  logic                    ref_armed;

  logic       accept;
  logic       code_legal;
  logic [2:0] idx_old;
  logic [2:0] idx_new;
  logic [2:0] idx_fwd;
  logic [2:0] idx_rev;
  logic       step_fwd;
  logic       step_rev;
  logic       counted;
  logic       skipped;
  logic       first_legal;
  logic       illegal;
  logic       timer_rst;
  logic       timer_sat;

  // position of a legal code in the forward commutation sequence
  function automatic logic [2:0] seq_idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b001:  idx = 3'd0;
      3'b011:  idx = 3'd1;
      3'b010:  idx = 3'd2;
      3'b110:  idx = 3'd3;
      3'b100:  idx = 3'd4;
      3'b101:  idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a   <= 3'b000;
      sync_s   <= 3'b000;
      cand     <= 3'b000;
      stab     <= '0;
      acc_code <= 3'b000;
    end else begin
      sync_a <= h_raw;
      sync_s <= sync_a;
      if (sync_s != cand) begin
        cand <= sync_s;
        stab <= '0;
      end else if (accept) begin
        acc_code <= cand;
      end else if (stab != STAB_MAX) begin
        stab <= stab + STAB_W'(1);
      end
    end
  end

  // acc_code rather than h is the reference, so an illegal code held on the pins is taken once
  always_comb begin
    accept      = (sync_s == cand) && (stab == STAB_MAX) && (cand != acc_code);
    code_legal  = (cand != 3'b000) && (cand != 3'b111);
    idx_old     = seq_idx(h);
    idx_new     = seq_idx(cand);
    idx_fwd     = (idx_old == 3'd5) ? 3'd0 : idx_old + 3'd1;
    idx_rev     = (idx_old == 3'd0) ? 3'd5 : idx_old - 3'd1;
    step_fwd    = (idx_new == idx_fwd);
    step_rev    = (idx_new == idx_rev);
    illegal     = accept && !code_legal;
    first_legal = accept && code_legal && !h_valid;
    counted     = accept && code_legal && h_valid && (step_fwd || step_rev);
    skipped     = accept && code_legal && h_valid && !(step_fwd || step_rev);
    timer_rst   = counted || first_legal || skipped;
    timer_sat   = (timer == TIMER_MAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h          <= 3'b000;
      h_valid    <= 1'b0;
      fault      <= 1'b0;
      dir        <= 1'b1;
      edge_pulse <= 1'b0;
      position   <= '0;
    end else begin
      edge_pulse <= counted;
      if (illegal) begin
        h       <= 3'b000;
        h_valid <= 1'b0;
        fault   <= 1'b1;
      end else if (accept) begin
        h       <= cand;
        h_valid <= 1'b1;
      end
      if (skipped) begin
        fault <= 1'b1;
      end
      if (counted) begin
        dir <= step_fwd;
      end
      if (clear_count) begin
        position <= '0;
      end else if (counted) begin
        position <= step_fwd ? position + COUNT_WIDTH'(1) : position - COUNT_WIDTH'(1);
      end
    end
  end

  // a saturated timer disarms the reference, so the first step after a stall reports no period
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer        <= '0;
      ref_armed    <= 1'b0;
      stalled      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= counted && ref_armed && !timer_sat;
      if (counted && ref_armed && !timer_sat) begin
        period <= timer + PERIOD_WIDTH'(1);
      end
      if (timer_rst) begin
        timer <= '0;
      end else if (!timer_sat) begin
        timer <= timer + PERIOD_WIDTH'(1);
      end
      if (counted || first_legal) begin
        ref_armed <= 1'b1;
      end else if (illegal || skipped || (timer == TIMER_PRE)) begin
        ref_armed <= 1'b0;
      end
      if (counted) begin
        stalled <= 1'b0;
      end else if (!timer_rst && (timer == TIMER_PRE)) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hall_conditioner.sv
// Bench for hall_conditioner: directed scenarios plus random Hall sequences, every cycle
// compared against an event-level reference model of the conditioner.
module tb_hall_conditioner;

  localparam int FC   = 8;
  localparam int PW   = 8;
  localparam int CW   = 16;
  localparam int TMAX = (1 << PW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    h_raw = 3'b001;
  logic          clear_count = 1'b0;
  logic [2:0]    h;
  logic          h_valid;
  logic          fault;
  logic          dir;
  logic          edge_pulse;
  logic [CW-1:0] position;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;

  hall_conditioner #(
    .FILTER_CYCLES(FC),
    .PERIOD_WIDTH (PW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .h_raw       (h_raw),
    .clear_count (clear_count),
    .h           (h),
    .h_valid     (h_valid),
    .fault       (fault),
    .dir         (dir),
    .edge_pulse  (edge_pulse),
    .position    (position),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int ep_seen = 0;
  int pv_seen = 0;

  // reference model state
  logic [2:0]    m_h;
  logic [2:0]    m_acc;
  bit            m_hv, m_fault, m_dir, m_ep, m_pv, m_stalled, m_armed;
  logic [CW-1:0] m_pos;
  logic [PW-1:0] m_period;
  int            m_n, m_t;
  logic [2:0]    hist[$];
  int            seq_code[6] = '{1, 3, 2, 6, 4, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq_code[i] == int'(c)) return i;
    return -1;
  endfunction

  function automatic logic [2:0] sample_at(input int k);
    if (k < 0) return 3'b000;
    return hist[k];
  endfunction

  task automatic model_reset();
    m_h = 3'b000; m_acc = 3'b000; m_hv = 0; m_fault = 0; m_dir = 1;
    m_ep = 0; m_pv = 0; m_stalled = 0; m_armed = 0;
    m_pos = '0; m_period = '0; m_n = 0; m_t = 0;
    hist.delete();
  endtask

  // a code is taken once it has been seen on FC+1 consecutive samples, two samples back
  task automatic model_edge(input logic [2:0] raw, input bit clr);
    int base; logic [2:0] c; bit stable; bit trst; int d;
    m_n++;
    hist.push_back(raw);
    if (hist.size() > FC + 3) void'(hist.pop_front());
    base = hist.size() - 3;
    c = sample_at(base);
    stable = 1;
    for (int k = 1; k <= FC; k++) if (sample_at(base - k) !== c) stable = 0;
    m_ep = 0; m_pv = 0; trst = 0;
    if (stable && c !== m_acc) begin
      m_acc = c;
      if (c == 3'b000 || c == 3'b111) begin
        m_h = 3'b000; m_hv = 0; m_fault = 1; m_armed = 0;
      end else if (!m_hv) begin
        m_h = c; m_hv = 1; trst = 1; m_armed = 1;
      end else begin
        d = (idx_of(c) - idx_of(m_h) + 6) % 6;
        if (d == 1 || d == 5) begin
          m_dir = (d == 1);
          m_pos = (d == 1) ? m_pos + 1'b1 : m_pos - 1'b1;
          m_ep = 1;
          if (m_armed && (m_n - 1 - m_t) < TMAX) begin
            m_period = PW'(m_n - m_t);
            m_pv = 1;
          end
          trst = 1; m_armed = 1; m_stalled = 0;
        end else begin
          m_fault = 1; trst = 1; m_armed = 0;
        end
        m_h = c;
      end
    end
    if (clr) m_pos = '0;
    if (trst) m_t = m_n;
    else if (m_n - m_t == TMAX) begin
      m_stalled = 1; m_armed = 0;
    end
  endtask

  // entered just after a falling edge; returns at the next falling edge
  task automatic tick(input logic [2:0] raw, input bit clr);
    h_raw = raw;
    clear_count = clr;
    @(posedge clock);
    model_edge(raw, clr);
    #1;
    ep_seen += int'(edge_pulse);
    pv_seen += int'(period_valid);
    chk("h", h, m_h);
    chk("h_valid", h_valid, m_hv);
    chk("fault", fault, m_fault);
    chk("dir", dir, m_dir);
    chk("edge_pulse", edge_pulse, m_ep);
    chk("position", position, m_pos);
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_pv);
    chk("stalled", stalled, m_stalled);
    @(negedge clock);
  endtask

  task automatic hold(input logic [2:0] code, input int cycles, input int clr_at);
    for (int i = 1; i <= cycles; i++) tick(code, i == clr_at);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_h"}, h, 3'b000);
    chk({tag, "_h_valid"}, h_valid, 1'b0);
    chk({tag, "_fault"}, fault, 1'b0);
    chk({tag, "_dir"}, dir, 1'b1);
    chk({tag, "_edge_pulse"}, edge_pulse, 1'b0);
    chk({tag, "_position"}, position, 16'd0);
    chk({tag, "_period"}, period, 8'd0);
    chk({tag, "_period_valid"}, period_valid, 1'b0);
    chk({tag, "_stalled"}, stalled, 1'b0);
  endtask

  initial begin
    int ep0, pv0, ri, pick, len, clr_at;
    logic [2:0] code;
    logic [CW-1:0] pos0;

    model_reset();
    repeat (3) @(negedge clock);
    #1 check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // power-up acceptance of 001, then one full forward revolution at 100 cycles per step
    hold(3'b001, 100, 0);
    chk("powerup_h", h, 3'b001);
    chk("powerup_edges", ep_seen, 0);
    chk("powerup_position", position, 16'd0);
    ep0 = ep_seen; pv0 = pv_seen;
    foreach (seq_code[i]) hold(3'(seq_code[(i + 1) % 6]), 100, 0);
    chk("fwd_edges", ep_seen - ep0, 6);
    chk("fwd_periods", pv_seen - pv0, 6);
    chk("fwd_position", position, 16'd6);
    chk("fwd_dir", dir, 1'b1);
    chk("fwd_period", period, 8'd100);

    // reverse three steps from a cleared count, then clear on the same cycle as a fourth step
    tick(3'b001, 1'b1);
    hold(3'b101, 100, 0);
    hold(3'b100, 100, 0);
    hold(3'b110, 100, 0);
    chk("rev_position", position, 16'hFFFD);
    chk("rev_dir", dir, 1'b0);
    ep0 = ep_seen;
    hold(3'b010, 100, FC + 3);
    chk("clr_step_edges", ep_seen - ep0, 1);
    chk("clr_position", position, 16'd0);

    // glitch rejection
    hold(3'b011, 100, 0);
    ep0 = ep_seen;
    hold(3'b001, FC - 3, 0);
    hold(3'b011, 100, 0);
    chk("glitch5_edges", ep_seen - ep0, 0);
    chk("glitch5_h", h, 3'b011);
    hold(3'b001, FC + 1, 0);
    hold(3'b011, 100, 0);
    chk("glitch9_edges", ep_seen - ep0, 2);

    // illegal code, recovery, skipped step
    ep0 = ep_seen;
    hold(3'b111, 40, 0);
    chk("illegal_h", h, 3'b000);
    chk("illegal_h_valid", h_valid, 1'b0);
    chk("illegal_fault", fault, 1'b1);
    hold(3'b001, 40, 0);
    chk("recover_h_valid", h_valid, 1'b1);
    chk("recover_edges", ep_seen - ep0, 0);
    pos0 = position;
    hold(3'b010, 40, 0);
    chk("skip_fault", fault, 1'b1);
    chk("skip_position", position, pos0);
    chk("skip_edges", ep_seen - ep0, 0);

    // stall: hold one step past timer saturation
    hold(3'b011, 300, 0);
    chk("stall_flag", stalled, 1'b1);
    ep0 = ep_seen; pv0 = pv_seen;
    hold(3'b001, 40, 0);
    chk("stall_next_edges", ep_seen - ep0, 1);
    chk("stall_next_periods", pv_seen - pv0, 0);
    chk("stall_cleared", stalled, 1'b0);

    // random walk of forward, reverse, skipped, illegal and short codes
    ri = 0;
    for (int it = 0; it < 60; it++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4) ri = (ri + 1) % 6;
      else if (pick < 7) ri = (ri + 5) % 6;
      else if (pick == 7) ri = $urandom_range(0, 5);
      if (pick == 8) code = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      else if (pick == 9) code = 3'($urandom_range(0, 7));
      else code = 3'(seq_code[ri]);
      len = $urandom_range(1, 120);
      clr_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len) : 0;
      hold(code, len, clr_at);
    end

    // asynchronous reset in mid-operation
    #2 reset_n = 1'b0;
    #1 check_reset_values("midreset");
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    hold(3'b110, 30, 0);
    chk("postreset_h", h, 3'b110);
    chk("postreset_position", position, 16'd0);
    hold(3'b100, 50, 0);
    chk("postreset_step", position, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
